// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM and ALU decoder for a multicycle RV32I datapath; ILLEGAL_TRAP_EN builds a sticky TRAP state for illegal instructions.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         imm_src,
  output logic [4:0]         alu_control,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);
  typedef enum logic [STATE_W-1:0] {
    FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECUTER = 6,
    EXECUTEI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, LUI = 11, TRAP = 12
  } state_t;
  state_t cur, nxt;
  logic pcw, irw, mw, rw;
  logic br_ok, taken;
  function automatic logic [4:0] alu_dec(input logic [2:0] f3, input logic f7, input logic r_type);
    case (f3)
      3'd0: alu_dec = (r_type && f7) ? 5'd1 : 5'd0;
      3'd1: alu_dec = 5'd7;
      3'd2: alu_dec = 5'd2;
      3'd3: alu_dec = 5'd3;
      3'd4: alu_dec = 5'd4;
      3'd5: alu_dec = f7 ? 5'd9 : 5'd8;
      3'd6: alu_dec = 5'd5;
      default: alu_dec = 5'd6;
    endcase
  endfunction
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= FETCH;
    else cur <= nxt;
  // beq/bne use SUB, blt/bge SLT, bltu/bgeu SLTU; funct3[0]^funct3[2] selects the sense of zero
  assign br_ok = funct3[2] | ~funct3[1];
  assign taken = br_ok & (zero ^ funct3[0] ^ funct3[2]);
  always_comb begin
    nxt = cur;
    pcw = 1'b0;
    irw = 1'b0;
    mw = 1'b0;
    rw = 1'b0;
    adr_src = 1'b0;
    result_src = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    imm_src = 3'd0;
    alu_control = 5'd0;
    illegal = 1'b0;
    case (cur)
      FETCH: begin
        alu_src_b = 2'd2;
        result_src = 2'd2;
        irw = mem_ready;
        pcw = mem_ready;
        nxt = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        imm_src = (op == 7'b1101111) ? 3'd3 : 3'd2;
        case (op)
          7'b0000011, 7'b0100011: nxt = MEMADR;
          7'b0110011: nxt = EXECUTER;
          7'b0010011: nxt = EXECUTEI;
          7'b1100011: nxt = BRANCH;
          7'b1101111: nxt = JAL;
          7'b0110111: nxt = LUI;
          default: begin
            illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            nxt = TRAP;
`else
            nxt = FETCH;
`endif
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        imm_src = {2'b00, op[5]};
        nxt = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        nxt = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'd1;
        rw = 1'b1;
        nxt = FETCH;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mw = 1'b1;
        nxt = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        alu_src_a = 2'd2;
        alu_control = alu_dec(funct3, funct7b5, 1'b1);
        nxt = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        alu_control = alu_dec(funct3, funct7b5, 1'b0);
        nxt = ALUWB;
      end
      ALUWB: begin
        rw = 1'b1;
        nxt = FETCH;
      end
      BRANCH: begin
        alu_src_a = 2'd2;
        alu_control = !br_ok ? 5'd0 : !funct3[2] ? 5'd1 : funct3[1] ? 5'd3 : 5'd2;
        pcw = taken;
        illegal = ~br_ok;
`ifdef ILLEGAL_TRAP_EN
        nxt = br_ok ? FETCH : TRAP;
`else
        nxt = FETCH;
`endif
      end
      JAL: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        pcw = 1'b1;
        nxt = ALUWB;
      end
      LUI: begin
        alu_src_a = 2'd3;
        alu_src_b = 2'd1;
        imm_src = 3'd4;
        nxt = ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        illegal = 1'b1;
        nxt = TRAP;
      end
`endif
      default: nxt = FETCH;
    endcase
  end
  // enables are masked combinationally so an asserted reset suppresses any update at once
  assign pc_write = pcw & ~reset;
  assign ir_write = irw & ~reset;
  assign mem_write = mw & ~reset;
  assign reg_write = rw & ~reset;
  assign state = cur;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the multicycle control FSM and ALU decoder.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset, zero, mem_ready, funct7b5;
  logic [6:0] op;
  logic [2:0] funct3;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [4:0] alu_control;
  logic [3:0] state;
  int errors = 0;
  int checks = 0;
  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal),
    .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    step(); step();
    check("rst_state", state, 0);
    check("rst_irw", ir_write, 0);
    check("rst_pcw", pc_write, 0);
    reset = 1'b0;
    #1;
    check("fetch_irw", ir_write, 1);
    check("fetch_pcw", pc_write, 1);
    check("fetch_b", alu_src_b, 2);
    check("fetch_res", result_src, 2);
    // R-type SUB
    op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b1;
    step(); check("r_dec", state, 1); check("r_dec_a", alu_src_a, 1); check("r_dec_imm", imm_src, 2);
    step(); check("r_exe", state, 6); check("r_sub", alu_control, 1); check("r_exe_rw", reg_write, 0);
    step(); check("r_wb", state, 8); check("r_wb_rw", reg_write, 1); check("r_wb_res", result_src, 0);
    step(); check("r_back", state, 0);
    // I-type: SRAI, SRLI, and ADDI with funct7b5 set must stay ADD
    op = 7'b0010011; funct3 = 3'd5; funct7b5 = 1'b1;
    step(); step(); check("i_state", state, 7); check("i_sra", alu_control, 9); check("i_b", alu_src_b, 1);
    step(); step(); funct7b5 = 1'b0;
    step(); step(); check("i_srl", alu_control, 8);
    step(); step(); funct3 = 3'd0; funct7b5 = 1'b1;
    step(); step(); check("i_add", alu_control, 0);
    step(); step(); check("i_back", state, 0);
    // load with three wait cycles in MEMREAD
    op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0;
    step(); step(); check("ld_adr", state, 2); check("ld_imm", imm_src, 0); check("ld_a", alu_src_a, 2);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check("ld_wait", state, 3); check("ld_adrsrc", adr_src, 1);
    end
    mem_ready = 1'b1;
    step(); check("ld_wb", state, 4); check("ld_res", result_src, 1); check("ld_rw", reg_write, 1);
    step(); check("ld_back", state, 0);
    // BGE: taken on zero=1, not taken on zero=0
    op = 7'b1100011; funct3 = 3'd5; zero = 1'b1;
    step(); step(); check("br_state", state, 9); check("br_slt", alu_control, 2); check("br_taken", pc_write, 1);
    step(); zero = 1'b0;
    step(); step(); check("br_nt", pc_write, 0);
    funct3 = 3'd1; #1; check("bne_taken", pc_write, 1); check("bne_sub", alu_control, 1);
    funct3 = 3'd6; #1; check("bltu_sltu", alu_control, 3);
    step(); check("br_back", state, 0);
    // JAL and LUI
    op = 7'b1101111;
    step(); check("jal_imm", imm_src, 3);
    step(); check("jal_state", state, 10); check("jal_pcw", pc_write, 1); check("jal_a", alu_src_a, 1);
    step(); check("jal_wb", reg_write, 1);
    step(); op = 7'b0110111;
    step(); step(); check("lui_state", state, 11); check("lui_a", alu_src_a, 3); check("lui_imm", imm_src, 4);
    step(); step(); check("lui_back", state, 0);
    // store held in MEMWRITE, then reset mid-hold
    op = 7'b0100011; funct3 = 3'd2;
    step(); step(); check("st_imm", imm_src, 1);
    mem_ready = 1'b0;
    step(); check("st_state", state, 5); check("st_mw", mem_write, 1);
    step(); check("st_hold", mem_write, 1);
    reset = 1'b1;
    #1; check("st_rst_state", state, 0); check("st_rst_mw", mem_write, 0);
    step(); reset = 1'b0; mem_ready = 1'b1;
    #1; check("post_rst_irw", ir_write, 1); check("post_rst_pcw", pc_write, 1);
    // illegal opcode
    op = 7'b1111111;
    step(); check("ill_dec", illegal, 1);
    step();
`ifdef ILLEGAL_TRAP_EN
    check("trap_state", state, 12); check("trap_ill", illegal, 1);
    step(); check("trap_hold", state, 12); check("trap_pcw", pc_write, 0);
`else
    check("ill_state", state, 0); check("ill_pulse", illegal, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM plus ALU decoder for the multicycle RV32I datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the ALU's alu_control input and consumes its zero flag for branch resolution.
- Sits between the instruction register and the datapath muxes, register file, PC and memory port.

Parameters:
- STATE_W, 4, width of the state register and debug state output.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces state to FETCH
- op  input  7  instruction[6:0] from the instruction register
- funct3  input  3  instruction[14:12]
- funct7b5  input  1  instruction[30]
- zero  input  1  ALU zero flag (1 when alu_result == 0)
- mem_ready  input  1  memory access completes this cycle
- pc_write  output  1  PC load enable
- adr_src  output  1  memory address: 0 = PC, 1 = alu_out
- mem_write  output  1  data memory write strobe
- ir_write  output  1  instruction register and old_pc load enable
- reg_write  output  1  register file write enable
- result_src  output  2  result mux: 0 = alu_out, 1 = read data, 2 = live alu_result
- alu_src_a  output  2  0 = PC, 1 = old_pc, 2 = rs1 (A), 3 = zero
- alu_src_b  output  2  0 = rs2 (B), 1 = immediate, 2 = constant 4
- imm_src  output  3  0 = I, 1 = S, 2 = B, 3 = J, 4 = U
- alu_control  output  5  0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA
- illegal  output  1  illegal instruction flag
- state  output  4  current state (debug)

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11, TRAP 12.
- Reset: state = FETCH asynchronously. While reset is high, pc_write, ir_write, mem_write and reg_write are forced to 0.
- Unlisted outputs default to 0 in every state; alu_control defaults to ADD.
- Transitions on the rising clk edge only.
- FETCH: adr_src 0, a 0, b 2, ADD, result_src 2. If mem_ready: ir_write = pc_write = 1, go to DECODE; else hold with both enables low.
- DECODE: a 1, b 1, ADD; imm_src = J if op = 1101111, else B. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - any other op -> illegal handling (see Optional Feature)
- MEMADR: a 2, b 1, ADD; imm_src I for loads, S for stores. Go to MEMREAD (op[5] = 0) or MEMWRITE (op[5] = 1).
- MEMREAD: adr_src 1; hold until mem_ready, then MEMWB.
- MEMWB: result_src 1, reg_write 1 -> FETCH.
- MEMWRITE: adr_src 1, mem_write 1; hold (strobe stays high) until mem_ready, then FETCH.
- EXECUTER: a 2, b 0 -> ALUWB. EXECUTEI: a 2, b 1, imm_src I -> ALUWB.
- ALU decode by funct3:
  - 000: ADD; SUB if EXECUTER and funct7b5
  - 001: SLL; 010: SLT; 011: SLTU; 100: XOR
  - 101: SRA if funct7b5, else SRL (R and I types)
  - 110: OR; 111: AND
- ALUWB: result_src 0, reg_write 1 -> FETCH.
- BRANCH: a 2, b 0, result_src 0. By funct3:
  - 000 SUB, taken = zero; 001 SUB, taken = !zero
  - 100 SLT, taken = !zero; 101 SLT, taken = zero
  - 110 SLTU, taken = !zero; 111 SLTU, taken = zero
  - 010 and 011: never taken, treated as illegal
  - pc_write = taken, same cycle; then FETCH
- JAL: a 1, b 2, ADD, result_src 0, pc_write 1 (target from alu_out) -> ALUWB, which writes PC+4.
- LUI: a 3, b 1, imm_src U, ADD -> ALUWB.
- Reset asserted in any state, including mid-hold in MEMWRITE: mem_write drops immediately and no PC or register update occurs.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal op or branch funct3 enters TRAP. TRAP asserts illegal = 1 and all enables 0, and is left only by reset.
- Undefined: TRAP state is not built. An illegal op returns DECODE -> FETCH as a NOP, with illegal pulsed high for that DECODE cycle. An illegal branch funct3 is a not-taken NOP.

Test Plan:
- Reset high mid-MEMWRITE -> state 0 and mem_write 0 in the same cycle; first FETCH after release with mem_ready = 1 -> ir_write = pc_write = 1.
- op 0110011, funct3 000, funct7b5 1 -> states 0, 1, 6, 8, 0; alu_control 1 in state 6; reg_write only in state 8.
- op 0010011, funct3 101, funct7b5 1 -> alu_control 9 in state 7; funct7b5 0 -> alu_control 8.
- op 0000011 with mem_ready low for 3 cycles in MEMREAD -> state 3 held 3 cycles, then 4 with result_src 1, reg_write 1.
- op 1100011, funct3 101, zero 1 -> alu_control 2, pc_write 1; repeat with zero 0 -> pc_write 0.
- op 1111111 -> with ILLEGAL_TRAP_EN: state 12, illegal held high; without: illegal pulses 1 cycle, back to state 0.
